iob_split_reg: RTL and testbench
================================

Name: iob_split_reg

Overview:
- Registered, parametrised successor to the two-way native-bus split used between the CPU core and the instruction/data buses.
- Routes one native master request (valid/address/wdata/wstrb, response rdata/ready) to one of N_SLAVES slave cat buses.
- Slave selection comes from an external select input or from address MSBs.
- Adds a request/response register stage, a per-transaction timeout watchdog and an error response for unmapped selects.

Parameters:
- N_SLAVES, 2, number of slave ports (>=2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- SEL_W, 1, select field width (2**SEL_W >= N_SLAVES).
- SEL_MODE, 0, 0 = select from m_sel; 1 = select from m_addr[ADDR_W-1 -: SEL_W].
- TIMEOUT, 255, cycles to wait for slave ready; 0 disables the watchdog.
- ERR_RDATA, 32'h0, rdata returned on error responses.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- m_valid, in, 1, master request valid.
- m_addr, in, ADDR_W, master address.
- m_wdata, in, DATA_W, write data.
- m_wstrb, in, DATA_W/8, byte strobes (0 = read).
- m_sel, in, SEL_W, slave select (SEL_MODE=0 only).
- m_rdata, out, DATA_W, registered read data.
- m_ready, out, 1, one-cycle response pulse.
- m_err, out, 1, qualifies m_ready: timeout or unmapped select.
- s_req, out, N_SLAVES*REQ_W, slave requests. REQ_W = 1+ADDR_W+DATA_W+DATA_W/8. Slave k occupies [k*REQ_W +: REQ_W]. Fields MSB to LSB: valid, address, wdata, wstrb.
- s_resp, in, N_SLAVES*RESP_W, slave responses. RESP_W = DATA_W+1. Fields MSB to LSB: rdata, ready.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; timeout counter and captured select clear.
  - All s_req bits, m_rdata, m_ready, m_err and busy go to 0 immediately.
  - A transaction in flight is abandoned; no response is given.
- Master protocol: the master holds valid/addr/wdata/wstrb stable until it samples m_ready=1.
- FSM states: IDLE, REQ, RESP.
- IDLE, m_valid=1:
  - Decode sel per SEL_MODE.
  - If sel < N_SLAVES: register address/wdata/wstrb and sel, go to REQ.
  - Otherwise: go to RESP with err=1 and rdata=ERR_RDATA; no slave is touched.
- REQ:
  - Registered request drives slave sel with valid=1.
  - All fields of the other slaves are 0.
  - Counter increments each cycle.
  - If s_resp ready of slave sel = 1: capture its rdata, drop valid the following cycle, go to RESP with err=0.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: drop valid, go to RESP with err=1 and rdata=ERR_RDATA.
  - Ready from an unselected slave is ignored.
  - Ready and timeout in the same cycle: ready wins, err=0.
- RESP: m_ready=1 for exactly one cycle with m_rdata/m_err valid, then IDLE.
  - m_rdata holds its value until the next response.
  - m_err is 0 whenever m_ready=0.
- Latency:
  - Slave ready in the first REQ cycle gives m_ready 2 cycles after m_valid is sampled in IDLE.
  - Each slave wait cycle adds 1.
  - Unmapped select gives m_ready 1 cycle after sampling.
- Back-to-back:
  - m_valid is only sampled in IDLE, so a request still asserted in the RESP cycle is not reissued.
  - A new request sampled in IDLE on the cycle after RESP is accepted; minimum 3 cycles per transaction.
- Inputs changing during REQ/RESP have no effect; the request is registered.
- Writes: the slave's rdata is captured and returned like a read; the master ignores it.

Test Plan:
- Reset then idle: rst pulse, m_valid=0 for 10 cycles -> s_req all 0, m_ready=0, busy=0 throughout.
- Read from slave 1, SEL_MODE=0:
  - Stimulus: m_sel=1, m_addr=0x100, m_wstrb=0; slave 1 ready at the first REQ cycle with rdata=0xCAFEF00D.
  - Response: slave 0 valid stays 0; m_ready one cycle later with m_rdata=0xCAFEF00D, m_err=0; total 2 cycles.
- Write with wait states:
  - Stimulus: m_sel=0, m_wdata=0x12345678, m_wstrb=4'hF; slave 0 ready after 5 cycles.
  - Response: slave 0 sees the exact wdata/wstrb, valid held 5 cycles; m_ready 1 cycle after slave ready.
- Timeout:
  - Stimulus: TIMEOUT=4, slave never ready.
  - Response: valid high 4 cycles then 0; m_ready=1, m_err=1, m_rdata=ERR_RDATA; the next request works normally.
- Unmapped select:
  - Stimulus: N_SLAVES=3, SEL_MODE=1, m_addr=0xC000_0000 (sel=3, SEL_W=2).
  - Response: no slave valid; m_ready+m_err the next cycle.
- Reset mid-transaction: rst asserted in REQ -> slave valid drops the same cycle without a clock edge; no m_ready; busy=0.

Source files
------------

// File: rtl/iob_split_reg.sv
// Registered 1-to-N native-bus split: one master request is routed to one slave chosen by
// m_sel or the address MSBs. Includes a per-transaction timeout and error responses for unmapped selects.
module iob_split_reg #(
  parameter int                N_SLAVES  = 2,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                SEL_W     = 1,
  parameter int                SEL_MODE  = 0,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA = '0
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                m_valid,
  input  logic [ADDR_W-1:0]                                   m_addr,
  input  logic [DATA_W-1:0]                                   m_wdata,
  input  logic [DATA_W/8-1:0]                                 m_wstrb,
  input  logic [SEL_W-1:0]                                    m_sel,
  output logic [DATA_W-1:0]                                   m_rdata,
  output logic                                                m_ready,
  output logic                                                m_err,
  output logic [N_SLAVES*(1+ADDR_W+DATA_W+DATA_W/8)-1:0]      s_req,
  input  logic [N_SLAVES*(DATA_W+1)-1:0]                      s_resp,
  output logic                                                busy
);
  localparam int STRB_W = DATA_W/8;
  localparam int REQ_W  = 1+ADDR_W+DATA_W+STRB_W;
  localparam int RESP_W = DATA_W+1;
  localparam int N_SEL  = 2**SEL_W;
  localparam int CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT-1 : 0);
  localparam logic [SEL_W:0]   N_SLV    = (SEL_W+1)'(N_SLAVES);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    sel_in;
  logic                sel_ok;
  logic [SEL_W-1:0]    sel_p0;
  logic [ADDR_W-1:0]   req_addr_p0;
  logic [DATA_W-1:0]   req_wdata_p0;
  logic [STRB_W-1:0]   req_wstrb_p0;
  logic [N_SEL-1:0]    s_rdy;
  logic [DATA_W-1:0]   s_rd [N_SEL];

  always_comb begin
    sel_in = m_sel;
    if (SEL_MODE != 0) sel_in = m_addr[ADDR_W-1 -: SEL_W];
  end

  assign sel_ok = {1'b0, sel_in} < N_SLV;
  assign busy   = (state != IDLE);

  // Unpack slave buses; select codes beyond N_SLAVES read as never-ready.
  for (genvar k = 0; k < N_SEL; k++) begin : g_slv
    if (k < N_SLAVES) begin : g_map
      assign s_rdy[k] = s_resp[k*RESP_W];
      assign s_rd[k]  = s_resp[k*RESP_W+1 +: DATA_W];
      assign s_req[k*REQ_W +: REQ_W] = (state == REQ && sel_p0 == SEL_W'(k)) ?
                                       {1'b1, req_addr_p0, req_wdata_p0, req_wstrb_p0} : '0;
    end else begin : g_unmap
      assign s_rdy[k] = 1'b0;
      assign s_rd[k]  = '0;
    end
  end

  // Stage p0: request capture in IDLE (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (state == IDLE && m_valid) begin
      req_addr_p0  <= m_addr;
      req_wdata_p0 <= m_wdata;
      req_wstrb_p0 <= m_wstrb;
    end
  end

  // Control FSM and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sel_p0  <= '0;
      m_rdata <= '0;
      m_ready <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      m_ready <= 1'b0;
      m_err   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (m_valid) begin
            if (sel_ok) begin
              sel_p0 <= sel_in;
              state  <= REQ;
            end else begin
              state   <= RESP;
              m_ready <= 1'b1;
              m_err   <= 1'b1;
              m_rdata <= ERR_RDATA;
            end
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (s_rdy[sel_p0]) begin
            state   <= RESP;
            m_ready <= 1'b1;
            m_rdata <= s_rd[sel_p0];
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            state   <= RESP;
            m_ready <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= ERR_RDATA;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_split_reg.sv
// Randomised bench for iob_split_reg (3 slaves, address-MSB select, timeout 8) against a
// transaction-level model that derives the expected latency and response from the request and the slave wait count.
module tb_iob_split_reg;
  localparam int N      = 3;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = 2;
  localparam int TO     = 8;
  localparam int SB     = DW/8;
  localparam int REQ_W  = 1+AW+DW+SB;
  localparam int RESP_W = DW+1;
  localparam logic [DW-1:0] ERRD = 32'hDEAD_BEEF;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  m_valid;
  logic [AW-1:0]         m_addr;
  logic [DW-1:0]         m_wdata;
  logic [SB-1:0]         m_wstrb;
  logic [SW-1:0]         m_sel;
  logic [DW-1:0]         m_rdata;
  logic                  m_ready;
  logic                  m_err;
  logic [N*REQ_W-1:0]    s_req;
  logic [N*RESP_W-1:0]   s_resp;
  logic                  busy;

  int n_vec = 0;
  int n_err = 0;

  iob_split_reg #(
    .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .SEL_MODE(1),
    .TIMEOUT(TO), .ERR_RDATA(ERRD)
  ) u_dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_sel(m_sel), .m_rdata(m_rdata), .m_ready(m_ready),
    .m_err(m_err), .s_req(s_req), .s_resp(s_resp), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*REQ_W-1:0] exp_req(input int sel, input logic [AW-1:0] a,
                                                 input logic [DW-1:0] w, input logic [SB-1:0] s);
    logic [N*REQ_W-1:0] r;
    r = '0;
    r[sel*REQ_W +: REQ_W] = {1'b1, a, w, s};
    return r;
  endfunction

  // Unselected slaves get random ready/rdata; the selected one is ready only when told.
  task automatic drive_resp(input int sel, input bit rdy, input logic [DW-1:0] rd);
    for (int k = 0; k < N; k++) begin
      if (k == sel) s_resp[k*RESP_W +: RESP_W] = {rdy ? rd : DW'($urandom), rdy};
      else          s_resp[k*RESP_W +: RESP_W] = {DW'($urandom), 1'($urandom)};
    end
  endtask

  // One master transaction starting in IDLE; returns in IDLE with m_valid low.
  task automatic run_txn(input logic [AW-1:0] a, input logic [DW-1:0] w, input logic [SB-1:0] s,
                         input int wait_n, input logic [DW-1:0] rd, input bit scramble);
    int sel;
    bit mapped;
    int v;
    bit exp_err;
    logic [DW-1:0] exp_rd;
    logic [N*REQ_W-1:0] er;
    sel    = int'(a[AW-1 -: SW]);
    mapped = (sel < N);
    if (!mapped) begin
      v = 0; exp_err = 1'b1; exp_rd = ERRD;
    end else if (wait_n + 1 <= TO) begin
      v = wait_n + 1; exp_err = 1'b0; exp_rd = rd;
    end else begin
      v = TO; exp_err = 1'b1; exp_rd = ERRD;
    end
    m_valid = 1'b1; m_addr = a; m_wdata = w; m_wstrb = s; m_sel = SW'($urandom);
    drive_resp(sel, 1'b0, rd);
    for (int c = 1; c <= v + 2; c++) begin
      @(posedge clk); #1;
      er = (mapped && c <= v) ? exp_req(sel, a, w, s) : '0;
      check("s_req", 256'(s_req), 256'(er));
      check("m_ready", 256'(m_ready), 256'(c == v + 1));
      check("m_err", 256'(m_err), 256'(c == v + 1 && exp_err));
      check("busy", 256'(busy), 256'(c <= v + 1));
      if (c >= v + 1) check("m_rdata", 256'(m_rdata), 256'(exp_rd));
      if (scramble && c <= v) begin
        m_addr = AW'($urandom); m_wdata = DW'($urandom); m_wstrb = SB'($urandom);
        m_sel = SW'($urandom);
      end
      if (c == v + 2) m_valid = 1'b0;
      drive_resp(sel, mapped && (c == wait_n + 1), rd);
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    rst = 1'b1; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0; m_sel = '0;
    s_resp = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_rdata", 256'(m_rdata), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_s_req", 256'(s_req), 256'(0));
      check("idle_m_ready", 256'(m_ready), 256'(0));
      check("idle_busy", 256'(busy), 256'(0));
      drive_resp(-1, 1'b0, '0);
    end

    // Directed: read slave 1, write slave 0 with waits, timeout, unmapped, boundary
    run_txn(32'h4000_0100, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b0);
    run_txn(32'h0000_0040, 32'h1234_5678, 4'hF, 4, 32'h0BAD_CAFE, 1'b0);
    run_txn(32'h8000_0010, 32'h0, 4'h0, 1000, 32'h1111_2222, 1'b0);
    run_txn(32'h4000_0200, 32'hA5A5_A5A5, 4'h3, 1, 32'h3333_4444, 1'b0);
    run_txn(32'hC000_0000, 32'h0, 4'h0, 0, 32'h5555_6666, 1'b0);
    run_txn(32'h8000_0020, 32'h0, 4'h0, TO - 1, 32'h7777_8888, 1'b0);
    run_txn(32'h0000_0030, 32'h0, 4'h0, TO, 32'h9999_AAAA, 1'b1);

    for (int t = 0; t < 60; t++) begin
      a = {SW'($urandom_range(0, 3)), (AW-SW)'($urandom)};
      run_txn(a, DW'($urandom), SB'($urandom), $urandom_range(0, 10), DW'($urandom),
              1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("gap_busy", 256'(busy), 256'(0));
      end
    end

    // Reset while a request is outstanding at slave 2
    m_valid = 1'b1; m_addr = 32'h8000_0ABC; m_wdata = 32'hFACE_0001; m_wstrb = 4'h5;
    drive_resp(2, 1'b0, '0);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_rst_s_req", 256'(s_req), 256'(exp_req(2, 32'h8000_0ABC, 32'hFACE_0001, 4'h5)));
    #2 rst = 1'b1;
    #1;
    check("async_s_req", 256'(s_req), 256'(0));
    check("async_busy", 256'(busy), 256'(0));
    check("async_m_ready", 256'(m_ready), 256'(0));
    check("async_m_rdata", 256'(m_rdata), 256'(0));
    m_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive_resp(2, 1'b1, 32'h1234_0000);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("post_rst_m_ready", 256'(m_ready), 256'(0));
      check("post_rst_busy", 256'(busy), 256'(0));
    end
    run_txn(32'h4000_0004, 32'h0, 4'h0, 2, 32'hBEEF_0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
